// File: rtl/skid_fallthrough_lat.sv
// Adapter from a pop/empty FIFO with multi-cycle read latency to a registered
// valid/ready stream; pops ahead on credit and catches returns in a skid ring.
module skid_fallthrough_lat #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter int SKID_DEPTH   = READ_LATENCY + 1,
   localparam int LVL_WIDTH   = $clog2(SKID_DEPTH + 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   output logic [DATA_WIDTH-1:0] dn_bus,
   output logic                  dn_val,
   input  logic                  dn_rdy,
   output logic [LVL_WIDTH-1:0]  level
);

   if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_lat
      $error("READ_LATENCY must be 1..8");
   end
   if (SKID_DEPTH < READ_LATENCY) begin : g_bad_depth
      $error("SKID_DEPTH must be >= READ_LATENCY");
   end

   localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);
   localparam logic [LVL_WIDTH-1:0] DEPTH_L = LVL_WIDTH'(SKID_DEPTH);

   logic [READ_LATENCY-1:0] pipe;
   logic [LVL_WIDTH-1:0]    inflight;
   logic [LVL_WIDTH-1:0]    buf_count;
   logic [LVL_WIDTH-1:0]    credit_used;
   logic [DATA_WIDTH-1:0]   mem [SKID_DEPTH];
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W-1:0]        wr_ptr;
   logic                    ret_vld;
   logic                    dn_active;
   logic                    buf_rd;
   logic                    bypass;
   logic                    buf_wr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + LVL_WIDTH'(pipe[i]);
      end
   end

   // Credit counts only registered state, so a word leaving this cycle
   // frees its slot for the next cycle's pop.
   assign credit_used = inflight + buf_count;
   assign fifo_pop    = ~rst & ~fifo_empty & (credit_used < DEPTH_L);
   assign ret_vld     = pipe[READ_LATENCY-1];
   assign dn_active   = ~dn_val | dn_rdy;
   assign buf_rd      = dn_active & (buf_count != '0);
   assign bypass      = dn_active & (buf_count == '0) & ret_vld;
   assign buf_wr      = ret_vld & ~bypass;
   assign level       = credit_used + LVL_WIDTH'(dn_val);

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= fifo_pop;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         buf_count <= '0;
      end else begin
         if (buf_rd) rd_ptr <= ptr_inc(rd_ptr);
         if (buf_wr) wr_ptr <= ptr_inc(wr_ptr);
         buf_count <= buf_count + LVL_WIDTH'(buf_wr) - LVL_WIDTH'(buf_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (buf_wr) mem[wr_ptr] <= fifo_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dn_val <= 1'b0;
         dn_bus <= '0;
      end else if (dn_active) begin
         if (buf_rd) begin
            dn_val <= 1'b1;
            dn_bus <= mem[rd_ptr];
         end else if (bypass) begin
            dn_val <= 1'b1;
            dn_bus <= fifo_data;
         end else begin
            dn_val <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_skid_fallthrough_lat.sv
// Bench for skid_fallthrough_lat: latency-4, 5-entry skid, checked every
// cycle against a queue-of-arrivals model of the adapter.
module tb_skid_fallthrough_lat;

   localparam int L  = 4;
   localparam int D  = 5;
   localparam int DW = 32;
   localparam int LW = $clog2(D + 2);

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] fifo_data;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [DW-1:0] dn_bus;
   logic          dn_val;
   logic          dn_rdy;
   logic [LW-1:0] level;

   skid_fallthrough_lat #(
      .DATA_WIDTH(DW),
      .READ_LATENCY(L),
      .SKID_DEPTH(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_data(fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop),
      .dn_bus(dn_bus),
      .dn_val(dn_val),
      .dn_rdy(dn_rdy),
      .level(level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            arr;
   } word_t;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int beats = 0;
   bit model_ok = 0;

   logic [DW-1:0] next_base = 32'h10;
   logic [DW-1:0] src_next = 0;
   logic [DW-1:0] exp_beat = 0;
   logic          dl_v [L];
   logic [DW-1:0] dl_d [L];

   word_t         q[$];
   logic [DW-1:0] mdl_next = 0;
   logic          m_val = 0;
   logic [DW-1:0] m_bus = 0;
   logic          m_pop = 0;

   logic rst_s = 1, empty_s = 1, rdy_s = 0, pop_s = 0, m_pop_s = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic d);
      @(posedge clk);
      #1;
      if (rst_s) begin
         src_next = next_base;
         exp_beat = next_base;
      end
      for (int i = L - 1; i > 0; i--) begin
         dl_v[i] = dl_v[i-1];
         dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = pop_s;
      dl_d[0] = src_next;
      if (pop_s) src_next = src_next + 1;
      fifo_data = dl_v[L-1] ? dl_d[L-1] : 'x;

      if (rst_s) begin
         q.delete();
         m_val = 0;
         m_bus = 0;
         mdl_next = next_base;
         model_ok = 1;
      end else begin
         if (!m_val || rdy_s) begin
            if (q.size() > 0 && q[0].arr <= cyc) begin
               m_bus = q[0].d;
               m_val = 1;
               void'(q.pop_front());
            end else begin
               m_val = 0;
            end
         end
         if (m_pop_s) begin
            q.push_back('{mdl_next, cyc + L});
            mdl_next = mdl_next + 1;
         end
      end
      cyc++;

      if (model_ok) begin
         chk("dn_val", dn_val, m_val);
         if (m_val) chk("dn_bus", dn_bus, m_bus);
         chk("level", level, q.size() + int'(m_val));
         chk("level_max", level <= LW'(D + 1), 1);
         if (dn_val) chk("dn_bus_known", $isunknown(dn_bus), 0);
      end

      rst = r;
      fifo_empty = e;
      dn_rdy = d;
      m_pop = !r && !e && (q.size() < D);
      #1;
      if (model_ok) begin
         chk("fifo_pop", fifo_pop, m_pop);
         if (e) chk("pop_when_empty", fifo_pop, 0);
      end

      if (dn_val && d && !r) begin
         chk("beat_order", dn_bus, exp_beat);
         exp_beat = exp_beat + 1;
         beats++;
      end
      rst_s = r;
      empty_s = e;
      rdy_s = d;
      pop_s = fifo_pop;
      m_pop_s = m_pop;
   endtask

   initial begin
      int b0;
      rst = 1;
      fifo_empty = 1;
      dn_rdy = 0;
      fifo_data = 'x;
      for (int i = 0; i < L; i++) begin
         dl_v[i] = 0;
         dl_d[i] = 0;
      end

      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      chk("rst_dn_val", dn_val, 0);
      chk("rst_level", level, 0);
      chk("rst_pop", fifo_pop, 0);

      b0 = beats;
      for (int i = 0; i < 20; i++) begin
         cycle(0, i >= 8, 1);
         if (i < 8) chk("stream_pop", fifo_pop, 1);
         if (i == 4) chk("lat_not_yet", dn_val, 0);
         if (i == 5) begin
            chk("lat_first_val", dn_val, 1);
            chk("lat_first_bus", dn_bus, 32'h10);
         end
      end
      chk("stream_beats", beats - b0, 8);

      next_base = 32'h200;
      cycle(1, 1, 0);
      for (int i = 0; i < 16; i++) cycle(0, 0, 0);
      chk("stall_level", level, D + 1);
      chk("stall_pop", fifo_pop, 0);
      chk("stall_val", dn_val, 1);
      chk("stall_bus", dn_bus, 32'h200);
      for (int i = 0; i < 20; i++) cycle(0, 0, 1);
      for (int i = 0; i < 12; i++) cycle(0, 1, 1);

      next_base = 32'h3000;
      cycle(1, 1, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      cycle(1, 0, 1);
      chk("rst_pulse_pop", fifo_pop, 0);
      next_base = 32'h4000;
      cycle(0, 1, 1);
      chk("post_rst_val", dn_val, 0);
      chk("post_rst_level", level, 0);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 1);
         chk("stale_dropped", dn_val, 0);
      end

      next_base = 32'h5000;
      cycle(1, 1, 0);
      for (int i = 0; i < 60; i++) cycle(0, i[0], 1);
      for (int i = 0; i < 12; i++) cycle(0, 1, 1);

      next_base = 32'h10000;
      cycle(1, 1, 0);
      b0 = beats;
      for (int k = 0; k < 10000 && (beats - b0) < 1000; k++) begin
         cycle(0,
               ((src_next - next_base) >= 1000) || ($urandom_range(0, 99) < 30),
               $urandom_range(0, 1) == 1);
      end
      chk("rand_beats", beats - b0, 1000);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1);
      chk("rand_level_drained", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
